seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Scan scheduler and serial driver for the multi-digit 7-segment Pmod (74HC595 chain).
//  - Holds one character register per digit, each written by the host.
//  - Time-multiplexes the digits at a fixed refresh rate.
//  - Shifts one 16-bit frame per digit slot out on clockPin/dataPin and commits it with latchPin.
//  Sits between the top-level counter/application logic and the Pmod pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, 1..8; index width DW = max(1,$clog2(NUM_DIGITS))
//  CLK_DIV       8      GCLK cycles per shift-clock half period and per latch pulse, >=1
//  REFRESH_DIV   50000  GCLK cycles per digit slot; elaboration error if <= 33*CLK_DIV+4
//  COMMON_ANODE  1      1: segment byte inverted on the wire; 0: active-high
// PORTS
//  GCLK      in   1           system clock, all logic on posedge
//  rst_n     in   1           asynchronous active-low reset
//  wr_en     in   1           write strobe for digit register
//  wr_idx    in   DW          digit to write; values >= NUM_DIGITS ignored
//  wr_data   in   5           {blank, hex[3:0]}; blank=1 turns digit fully off
//  dp_mask   in   NUM_DIGITS  decimal point per digit, sampled at frame load
//  busy      out  1           1 from LOAD through LATCH, i.e. frame in flight
//  digit_idx out  DW          digit currently being driven/shown
//  clockPin  out  1           595 SRCLK
//  dataPin   out  1           595 SER, MSB first
//  latchPin  out  1           595 RCLK
// BEHAVIOUR
//  Reset (async, immediate):
//   - all digit regs = 5'b1_0000 (blank); digit_idx=0; state IDLE.
//   - refresh count=0; clockPin=dataPin=latchPin=0; busy=0.
//  Writes:
//   - wr_en with valid wr_idx updates the register on the next edge, any state.
//   - The in-flight frame uses its LOAD snapshot, so a mid-frame write shows on the next visit to that digit.
//  Refresh counter:
//   - counts 0..REFRESH_DIV-1 and wraps; a tick fires on wrap.
//   - A tick while busy sets a one-deep pending flag, serviced at IDLE. Never dropped or doubled.
//  Frame = {seg[7:0], sel[7:0]}, 16 bits, MSB first:
//   - seg = {dp,g,f,e,d,c,b,a} for digit_idx, active-high before inversion.
//   - hex 0-F -> 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//   - dp = dp_mask[digit_idx]; blank forces seg=8'h00, including dp.
//   - COMMON_ANODE=1 sends ~seg.
//   - sel = 8'b1 << digit_idx, always active-high; upper bits 0.
//  FSM:
//   - IDLE -> LOAD on tick or pending.
//   - LOAD (1 cycle): snapshot frame, bit count=15, clockPin=0, dataPin=frame[15].
//   - SHIFT_LO: CLK_DIV cycles, clockPin=0 -> SHIFT_HI.
//   - SHIFT_HI: CLK_DIV cycles, clockPin=1; at its end, if count==0 -> LATCH, else count--, present the next bit, -> SHIFT_LO.
//   - dataPin is stable across each rising clockPin edge.
//   - LATCH: clockPin=0, latchPin=1 for CLK_DIV cycles.
//   - LATCH exit: latchPin=0, digit_idx=(digit_idx==NUM_DIGITS-1)?0:digit_idx+1, -> IDLE.
//  Frame length = 1 + 32*CLK_DIV + CLK_DIV GCLK cycles; exactly 16 clockPin rises and 1 latch pulse per frame.
//  dataPin=0 outside SHIFT states.
//  Reset mid-frame: pins drop at once, no latch pulse, and the partial frame is never committed.
// TESTING  (CLK_DIV=2, REFRESH_DIV=100, NUM_DIGITS=4, COMMON_ANODE=1 unless noted)
//  1 Reset, no writes -> first LOAD at cycle 100; frame 16'hFF01; 16 SRCLK rises; 2-cycle latch; digit_idx->1.
//  2 wr idx0=5'h03, dp_mask=4'b0001 -> digit0 frame = {~8'hCF, 8'h01} = 16'h3001.
//  3 idx0..3 = 0,1,2,3 -> sel sequence 01,02,04,08,01; seg C0,F9,A4,B0 repeats.
//  4 wr idx2=5'h0A during digit2 SHIFT -> current frame keeps old seg; next digit2 frame seg=~77=88.
//  5 rst_n low mid-SHIFT_HI -> all pins 0 same cycle, no latch; after release, digit0 blank frame FF01 at cycle 100.
//  6 NUM_DIGITS=3, wr_idx=3 -> no register changes; scan wraps 2->0 (sel 04 -> 01).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler and serial 74HC595 driver for a multi-digit 7-segment Pmod.
// Each digit slot shifts one {seg,sel} frame MSB first, then pulses the latch.

module seg7_digit_reg (
  input  logic       GCLK,
  input  logic       rst_n,
  input  logic       we,
  input  logic [4:0] d,
  output logic [4:0] q
);
  always_ff @(posedge GCLK or negedge rst_n) begin
    if (!rst_n)  q <= 5'b1_0000;
    else if (we) q <= d;
  end
endmodule

module seg7_scan_ctrl #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int CLK_DIV      = 8,
  parameter  int REFRESH_DIV  = 50000,
  parameter  int COMMON_ANODE = 1,
  localparam int DW           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  GCLK,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_idx,
  input  logic [4:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic [DW-1:0]         digit_idx,
  output logic                  clockPin,
  output logic                  dataPin,
  output logic                  latchPin
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHLO  = 3'd2;
  localparam logic [2:0] S_SHHI  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_nd
    $error("seg7_scan_ctrl: NUM_DIGITS must be 1..8");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("seg7_scan_ctrl: CLK_DIV must be >= 1");
  end
  // A slot must hold a whole frame plus margin, so at most one tick lands per frame.
  if (REFRESH_DIV <= 33*CLK_DIV + 4) begin : g_bad_refresh
    $error("seg7_scan_ctrl: REFRESH_DIV too small for one frame");
  end

  logic [NUM_DIGITS-1:0][4:0] digit_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seg7_digit_reg u_reg (
      .GCLK  (GCLK),
      .rst_n (rst_n),
      .we    (wr_en && (wr_idx == DW'(i))),
      .d     (wr_data),
      .q     (digit_q[i])
    );
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 7'h3F;  4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;  4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;  4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;  4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;  4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;  4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;  4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;  default: hex_seg = 7'h71;
    endcase
  endfunction

  logic [4:0]  cur;
  logic [7:0]  seg, seg_wire, sel;
  logic [15:0] frame;

  always_comb begin
    cur      = digit_q[digit_idx];
    seg      = cur[4] ? 8'h00 : {dp_mask[digit_idx], hex_seg(cur[3:0])};
    seg_wire = (COMMON_ANODE != 0) ? ~seg : seg;
    sel      = 8'd1 << digit_idx;
    frame    = {seg_wire, sel};
  end

  logic [RW-1:0] rcnt;
  logic          tick;

  assign tick = (rcnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge GCLK or negedge rst_n) begin
    if (!rst_n)    rcnt <= '0;
    else if (tick) rcnt <= '0;
    else           rcnt <= rcnt + 1'b1;
  end

  logic [2:0]    state;
  logic          pend;
  logic [CW-1:0] dcnt;
  logic [3:0]    nbits;
  logic [15:0]   sh;
  logic          div_done;
  logic [DW-1:0] idx_nxt;

  assign div_done = (dcnt == CW'(CLK_DIV - 1));
  assign idx_nxt  = (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge GCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend      <= 1'b0;
      dcnt      <= '0;
      nbits     <= '0;
      sh        <= '0;
      clockPin  <= 1'b0;
      dataPin   <= 1'b0;
      latchPin  <= 1'b0;
      digit_idx <= '0;
    end else begin
      // A tick during a frame is remembered once and serviced on return to IDLE.
      if (tick && state != S_IDLE) pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick || pend) begin
            state    <= S_LOAD;
            pend     <= 1'b0;
            sh       <= frame;
            nbits    <= 4'd15;
            clockPin <= 1'b0;
            dataPin  <= frame[15];
            dcnt     <= '0;
          end
        end
        S_LOAD: begin
          state <= S_SHLO;
          dcnt  <= '0;
        end
        S_SHLO: begin
          if (div_done) begin
            dcnt     <= '0;
            clockPin <= 1'b1;
            state    <= S_SHHI;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_SHHI: begin
          if (div_done) begin
            dcnt     <= '0;
            clockPin <= 1'b0;
            if (nbits == 4'd0) begin
              state    <= S_LATCH;
              latchPin <= 1'b1;
              dataPin  <= 1'b0;
            end else begin
              // Next bit changes together with the falling clock edge.
              nbits   <= nbits - 1'b1;
              sh      <= {sh[14:0], 1'b0};
              dataPin <= sh[14];
              state   <= S_SHLO;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (div_done) begin
            dcnt      <= '0;
            latchPin  <= 1'b0;
            digit_idx <= idx_nxt;
            state     <= S_IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          clockPin <= 1'b0;
          dataPin  <= 1'b0;
          latchPin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a 4-digit and a 3-digit instance scanned side by side,
// frames decoded off the pins and checked against a queue of expected frames.

module tb_seg7_scan_ctrl;
  localparam int CD = 2;
  localparam int RD = 100;
  localparam logic [7:0] SEGT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                       8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic GCLK = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]      wr_en;
  logic [1:0][1:0] wr_idx;
  logic [1:0][4:0] wr_data;
  logic [1:0][3:0] dpm;
  wire  [1:0]      busy, ck, dt, lt;
  wire  [1:0]      didx_a, didx_b;

  always #5 GCLK = ~GCLK;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(CD), .REFRESH_DIV(RD), .COMMON_ANODE(1)) u_dut_a (
    .GCLK(GCLK), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_idx(wr_idx[0]), .wr_data(wr_data[0]),
    .dp_mask(dpm[0]), .busy(busy[0]), .digit_idx(didx_a), .clockPin(ck[0]),
    .dataPin(dt[0]), .latchPin(lt[0]));

  seg7_scan_ctrl #(.NUM_DIGITS(3), .CLK_DIV(CD), .REFRESH_DIV(RD), .COMMON_ANODE(1)) u_dut_b (
    .GCLK(GCLK), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_idx(wr_idx[1]), .wr_data(wr_data[1]),
    .dp_mask(dpm[1][2:0]), .busy(busy[1]), .digit_idx(didx_b), .clockPin(ck[1]),
    .dataPin(dt[1]), .latchPin(lt[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference model of the digit registers and scan position
  logic [4:0]  m_reg [2][8];
  int          m_idx [2];
  int          nd    [2] = '{4, 3};
  int          frames[2] = '{0, 0};
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  function automatic logic [15:0] exp_frame(input int u);
    logic [4:0] r;
    logic [7:0] s;
    logic [7:0] sl;
    int d;
    d  = m_idx[u];
    r  = m_reg[u][d];
    s  = r[4] ? 8'h00 : (SEGT[r[3:0]] | {dpm[u][d], 7'b0});
    sl = 8'd1 << d;
    return {~s, sl};
  endfunction

  function automatic logic [1:0] get_didx(input int u);
    return (u == 0) ? didx_a : didx_b;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u] = 0;
      for (int d = 0; d < 8; d++) m_reg[u][d] = 5'h10;
    end
  endtask

  // pin-level frame decoder
  logic [15:0] sr   [2];
  int          rises[2];
  int          llen [2];
  logic        pbusy[2], pck[2], plt[2];

  always @(negedge GCLK) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        sr[u] = '0; rises[u] = 0; llen[u] = 0;
        pbusy[u] = 1'b0; pck[u] = 1'b0; plt[u] = 1'b0;
        if (u == 0) q0.delete(); else q1.delete();
      end else begin
        if (busy[u] && !pbusy[u]) begin
          chk("didx_at_load", {30'd0, get_didx(u)}, m_idx[u]);
          if (u == 0) q0.push_back(exp_frame(0)); else q1.push_back(exp_frame(1));
        end
        if (ck[u] && !pck[u]) begin
          sr[u] = {sr[u][14:0], dt[u]};
          rises[u]++;
        end
        if (lt[u]) llen[u]++;
        if (!lt[u] && plt[u]) begin
          logic [15:0] e;
          logic        have;
          have = (u == 0) ? (q0.size() != 0) : (q1.size() != 0);
          chk("frame_expected", {31'd0, have}, 1);
          if (have) begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk((u == 0) ? "frame_a" : "frame_b", {16'd0, sr[u]}, {16'd0, e});
          end
          chk("srclk_rises", rises[u], 16);
          chk("latch_len", llen[u], CD);
          chk("data_in_latch", {31'd0, dt[u]}, 0);
          m_idx[u] = (m_idx[u] == nd[u] - 1) ? 0 : m_idx[u] + 1;
          frames[u]++;
          rises[u] = 0;
          llen[u]  = 0;
        end
        pbusy[u] = busy[u];
        pck[u]   = ck[u];
        plt[u]   = lt[u];
      end
    end
  end

  task automatic wr(input int u, input int idx, input logic [4:0] d);
    wr_en[u]   = 1'b1;
    wr_idx[u]  = 2'(idx);
    wr_data[u] = d;
    @(posedge GCLK); #1;
    wr_en[u] = 1'b0;
    if (idx < nd[u]) m_reg[u][idx] = d;
  endtask

  task automatic first_load();
    int n = 0;
    while (n < 1000) begin
      @(posedge GCLK); #1;
      n++;
      if (busy[0]) break;
    end
    chk("first_load_cycle", n, RD);
  endtask

  task automatic wait_frames(input int u, input int target);
    int n = 0;
    while (frames[u] < target && n < 5000) begin
      @(posedge GCLK); #1;
      n++;
    end
    chk("wait_frames", {31'd0, frames[u] >= target}, 1);
  endtask

  task automatic wait_busy(input int u, input int idx);
    int n = 0;
    while (!(busy[u] && get_didx(u) == 2'(idx)) && n < 1000) begin
      @(posedge GCLK); #1;
      n++;
    end
    chk("wait_busy", {31'd0, n < 1000}, 1);
  endtask

  task automatic chk_pins_low(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_busy"},  {31'd0, busy[u]}, 0);
      chk({tag, "_clk"},   {31'd0, ck[u]},   0);
      chk({tag, "_data"},  {31'd0, dt[u]},   0);
      chk({tag, "_latch"}, {31'd0, lt[u]},   0);
      chk({tag, "_didx"},  {30'd0, get_didx(u)}, 0);
    end
  endtask

  initial begin
    int n;
    wr_en = '0; wr_idx = '0; wr_data = '0; dpm = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge GCLK);
    #1;
    chk_pins_low("reset");
    rst_n = 1'b1;

    // blank digit 0 frame after a full refresh slot
    first_load();
    repeat (2) @(posedge GCLK);
    #1;

    // load digits mid-frame: A = 3(+dp),1,2,3 ; B = 0,1,2 and an ignored index 3
    wr(0, 0, 5'h03);
    dpm[0] = 4'b0001;
    wr(0, 1, 5'h01);
    wr(0, 2, 5'h02);
    wr(0, 3, 5'h03);
    wr(1, 0, 5'h00);
    wr(1, 1, 5'h01);
    wr(1, 2, 5'h02);
    wr(1, 3, 5'h08);
    wait_frames(0, 5);

    // plain 0,1,2,3 pattern, no decimal points
    wait_busy(0, 1);
    wr(0, 0, 5'h00);
    dpm[0] = 4'b0000;
    wait_frames(0, 10);

    // write to the digit being shifted: current frame keeps its snapshot
    wait_busy(0, 2);
    wr(0, 2, 5'h0A);
    wait_frames(0, frames[0] + 5);

    // reset in the middle of a shift-clock high phase
    n = 0;
    while (!(busy[0] && ck[0]) && n < 1000) begin
      @(posedge GCLK); #3;
      n++;
    end
    chk("found_shift_hi", {31'd0, ck[0]}, 1);
    rst_n = 1'b0;
    #1;
    chk_pins_low("midreset");
    model_reset();
    repeat (3) @(posedge GCLK);
    #1;
    chk_pins_low("midreset_hold");
    rst_n = 1'b1;
    first_load();
    wait_frames(0, frames[0] + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
